// File: rtl/sum_pkg.sv
// Shared definitions for the nibble-serial adder sequencer: nibble width and FSM state encoding.
package sum_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sum_4.sv
// 4-bit ripple-carry adder shared by the sequencer; purely combinational.
module sum_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cr,
  output logic [3:0] s,
  output logic       crp
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cr;
    for (int i = 0; i < 4; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    crp = c[4];
  end

endmodule

// File: rtl/sum_seq_ctrl.sv
// Wide adder built by stepping one sum_4 across the operands, LSB nibble first, with a carry register.
// Optional macro SUM_SEQ_OVF_EN adds ovf_out, the signed overflow of the final result.
module sum_seq_ctrl
  import sum_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    start_in,
  input  logic [4*NIBBLES-1:0]    a_in,
  input  logic [4*NIBBLES-1:0]    b_in,
  input  logic                    cr_in,
  output logic                    busy_out,
  output logic                    done_out,
  output logic [4*NIBBLES-1:0]    s_out,
`ifdef SUM_SEQ_OVF_EN
  output logic                    ovf_out,
`endif
  output logic                    crp_out
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int CW = $clog2(NIBBLES);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    a_reg, b_reg, s_reg;
  logic            carry_reg, crp_reg;
  logic            accept, last;
  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_s;
  logic            nib_crp;

  assign accept = start_in && ((state == ST_IDLE) || (state == ST_DONE));
  assign last   = (cnt == CW'(NIBBLES - 1));
  assign nib_a  = a_reg[NIBBLE_W*cnt +: NIBBLE_W];
  assign nib_b  = b_reg[NIBBLE_W*cnt +: NIBBLE_W];

  sum_4 u_sum_4 (
    .a   (nib_a),
    .b   (nib_b),
    .cr  (carry_reg),
    .s   (nib_s),
    .crp (nib_crp)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_RUN;
      ST_RUN:  if (last)   state_nxt = ST_DONE;
      ST_DONE: state_nxt = accept ? ST_RUN : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Result nibbles are written in place; the partial sum is visible while busy.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      a_reg     <= '0;
      b_reg     <= '0;
      s_reg     <= '0;
      carry_reg <= 1'b0;
      crp_reg   <= 1'b0;
      cnt       <= '0;
    end else if (accept) begin
      a_reg     <= a_in;
      b_reg     <= b_in;
      carry_reg <= cr_in;
      cnt       <= '0;
    end else if (state == ST_RUN) begin
      s_reg[NIBBLE_W*cnt +: NIBBLE_W] <= nib_s;
      carry_reg <= nib_crp;
      if (last) begin
        crp_reg <= nib_crp;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef SUM_SEQ_OVF_EN
  logic ovf_reg;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      ovf_reg <= 1'b0;
    else if (accept)
      ovf_reg <= 1'b0;
    else if ((state == ST_RUN) && last)
      ovf_reg <= (a_reg[W-1] == b_reg[W-1]) && (nib_s[NIBBLE_W-1] != a_reg[W-1]);
  end

  assign ovf_out = ovf_reg;
`endif

  assign busy_out = (state == ST_RUN);
  assign done_out = (state == ST_DONE);
  assign s_out    = s_reg;
  assign crp_out  = crp_reg;

endmodule

// File: tb/tb_sum_seq_ctrl.sv
// Directed bench for sum_seq_ctrl (NIBBLES=4); define SUM_SEQ_OVF_EN to cover ovf_out as well.
module tb_sum_seq_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start_in;
  logic [15:0] a_in, b_in;
  logic        cr_in;
  logic        busy_out, done_out, crp_out;
  logic [15:0] s_out;
`ifdef SUM_SEQ_OVF_EN
  logic        ovf_out;
`endif

  int ncmp = 0;
  int nfail = 0;

  sum_seq_ctrl #(.NIBBLES(4)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start_in (start_in),
    .a_in     (a_in),
    .b_in     (b_in),
    .cr_in    (cr_in),
    .busy_out (busy_out),
    .done_out (done_out),
    .s_out    (s_out),
`ifdef SUM_SEQ_OVF_EN
    .ovf_out  (ovf_out),
`endif
    .crp_out  (crp_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drives a request, returns at the negedge where done_out is seen.
  // k_done is the number of negedges waited (0 if it never came); busy_cnt counts busy negedges.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cr,
                        output int k_done, output int busy_cnt);
    a_in = a; b_in = b; cr_in = cr; start_in = 1'b1;
    k_done = 0; busy_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_in);
      if (k == 1) start_in = 1'b0;
      if (done_out) begin
        k_done = k;
        break;
      end
      if (busy_out) busy_cnt++;
    end
  endtask

  int  kd, bc;
  logic saw_done;

  initial begin
    rst_in = 1'b1; start_in = 1'b0; a_in = '0; b_in = '0; cr_in = 1'b0;
    repeat (2) @(negedge clk_in);
    check("rst_busy", busy_out, 0);
    check("rst_done", done_out, 0);
    check("rst_s", s_out, 0);
    check("rst_crp", crp_out, 0);
    rst_in = 1'b0;
    @(negedge clk_in);

    // Basic add and latency
    run_op(16'h1234, 16'h4321, 1'b0, kd, bc);
    check("t1_s", s_out, 32'h5555);
    check("t1_crp", crp_out, 0);
    check("t1_latency", kd, 5);
    check("t1_busy_cycles", bc, 4);
`ifdef SUM_SEQ_OVF_EN
    check("t1_ovf", ovf_out, 0);
`endif
    @(negedge clk_in);
    check("t1_hold_s", s_out, 32'h5555);
    check("t1_done_pulse", done_out, 0);

    // Carry rippling across all nibbles
    run_op(16'hFFFF, 16'h0001, 1'b0, kd, bc);
    check("t2_s", s_out, 32'h0000);
    check("t2_crp", crp_out, 1);
    @(negedge clk_in);

    // Carry-in, then back-to-back start accepted in DONE
    run_op(16'hFFFF, 16'h0000, 1'b1, kd, bc);
    check("t3a_s", s_out, 32'h0000);
    check("t3a_crp", crp_out, 1);
    run_op(16'h0000, 16'h0000, 1'b0, kd, bc);
    check("t3b_s", s_out, 32'h0000);
    check("t3b_crp", crp_out, 0);
    check("t3b_spacing", kd, 5);
    @(negedge clk_in);

    // Start pulsed during RUN must be ignored
    a_in = 16'h00F0; b_in = 16'h0010; cr_in = 1'b0; start_in = 1'b1;
    kd = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_in);
      start_in = 1'b0;
      if (k == 2) begin
        a_in = 16'hAAAA; b_in = 16'h5555; cr_in = 1'b1; start_in = 1'b1;
      end
      if (done_out) begin
        kd = k;
        break;
      end
    end
    start_in = 1'b0;
    check("t4_s", s_out, 32'h0100);
    check("t4_crp", crp_out, 0);
    check("t4_latency", kd, 5);
    @(negedge clk_in);
    check("t4_no_restart", busy_out, 0);

    // Reset mid-RUN
    a_in = 16'h8000; b_in = 16'h8000; cr_in = 1'b0; start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    check("t5_rst_busy", busy_out, 0);
    check("t5_rst_done", done_out, 0);
    check("t5_rst_s", s_out, 0);
    check("t5_rst_crp", crp_out, 0);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk_in);
      if (done_out) saw_done = 1'b1;
    end
    rst_in = 1'b0;
    repeat (4) begin
      @(negedge clk_in);
      if (done_out) saw_done = 1'b1;
    end
    check("t5_no_done", saw_done, 0);
    run_op(16'h0001, 16'h0001, 1'b0, kd, bc);
    check("t5_after_s", s_out, 32'h0002);
    check("t5_after_latency", kd, 5);
    @(negedge clk_in);

`ifdef SUM_SEQ_OVF_EN
    run_op(16'h7FFF, 16'h0001, 1'b0, kd, bc);
    check("ovf1_s", s_out, 32'h8000);
    check("ovf1_ovf", ovf_out, 1);
    check("ovf1_crp", crp_out, 0);
    @(negedge clk_in);
    run_op(16'h8000, 16'h8000, 1'b0, kd, bc);
    check("ovf2_s", s_out, 32'h0000);
    check("ovf2_ovf", ovf_out, 1);
    check("ovf2_crp", crp_out, 1);
    @(negedge clk_in);
    run_op(16'h1234, 16'h4321, 1'b0, kd, bc);
    check("ovf3_ovf", ovf_out, 0);
    @(negedge clk_in);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
